// File: rtl/residual_skip_join.sv
// Residual join: skip words are buffered in a FIFO and added to main-path words
// one-for-one through a 3-stage single-precision adder, with selectable ReLU placement.

module fp_add_sub (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        sub,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        valid_out
);

   // Stage 1: classify, order operands by magnitude
   logic        sb_eff, a_nan, b_nan, a_inf, b_inf, swap;
   logic [30:0] mag_a, mag_b;
   logic [7:0]  exp_big, exp_small;
   logic [23:0] man_a, man_b;
   logic        spec_c;
   logic [31:0] spec_val_c;

   logic        s1_valid, s1_special, s1_sign, s1_sub;
   logic [31:0] s1_spec_val;
   logic [7:0]  s1_exp, s1_diff;
   logic [23:0] s1_man_big, s1_man_small;

   always_comb begin
      sb_eff     = b[31] ^ sub;
      a_nan      = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
      b_nan      = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
      a_inf      = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
      b_inf      = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
      // subnormal operands are flushed to zero
      mag_a      = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
      mag_b      = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
      man_a      = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
      man_b      = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
      swap       = mag_b > mag_a;
      exp_big    = swap ? b[30:23] : a[30:23];
      exp_small  = swap ? a[30:23] : b[30:23];
      spec_c     = 1'b0;
      spec_val_c = 32'd0;
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff))) begin
         spec_c     = 1'b1;
         spec_val_c = 32'h7fc0_0000;
      end else if (a_inf) begin
         spec_c     = 1'b1;
         spec_val_c = {a[31], 8'hff, 23'd0};
      end else if (b_inf) begin
         spec_c     = 1'b1;
         spec_val_c = {sb_eff, 8'hff, 23'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid     <= 1'b0;
         s1_special   <= 1'b0;
         s1_spec_val  <= 32'd0;
         s1_sign      <= 1'b0;
         s1_sub       <= 1'b0;
         s1_exp       <= 8'd0;
         s1_diff      <= 8'd0;
         s1_man_big   <= 24'd0;
         s1_man_small <= 24'd0;
      end else begin
         s1_valid     <= valid_in;
         s1_special   <= spec_c;
         s1_spec_val  <= spec_val_c;
         s1_sign      <= swap ? sb_eff : a[31];
         s1_sub       <= a[31] ^ sb_eff;
         s1_exp       <= exp_big;
         s1_diff      <= exp_big - exp_small;
         s1_man_big   <= swap ? man_b : man_a;
         s1_man_small <= swap ? man_a : man_b;
      end
   end

   // Stage 2: align the smaller operand (guard/round/sticky kept) and add
   logic [26:0] small_ext, small_shift, small_al;
   logic [27:0] sum_c;

   logic        s2_valid, s2_special, s2_sign, s2_sub;
   logic [31:0] s2_spec_val;
   logic [7:0]  s2_exp;
   logic [27:0] s2_sum;

   always_comb begin
      small_ext   = {s1_man_small, 3'b000};
      small_shift = small_ext >> s1_diff;
      if (s1_diff >= 8'd27)
         small_al = {26'd0, |s1_man_small};
      else
         small_al = {small_shift[26:1],
                     small_shift[0] | (|(small_ext & ~(27'h7ff_ffff << s1_diff)))};
      if (s1_sub)
         sum_c = {1'b0, s1_man_big, 3'b000} - {1'b0, small_al};
      else
         sum_c = {1'b0, s1_man_big, 3'b000} + {1'b0, small_al};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid    <= 1'b0;
         s2_special  <= 1'b0;
         s2_spec_val <= 32'd0;
         s2_sign     <= 1'b0;
         s2_sub      <= 1'b0;
         s2_exp      <= 8'd0;
         s2_sum      <= 28'd0;
      end else begin
         s2_valid    <= s1_valid;
         s2_special  <= s1_special;
         s2_spec_val <= s1_spec_val;
         s2_sign     <= s1_sign;
         s2_sub      <= s1_sub;
         s2_exp      <= s1_exp;
         s2_sum      <= sum_c;
      end
   end

   // Stage 3: normalise, round to nearest even, pack
   logic [4:0]        lead, shl;
   logic [26:0]       norm;
   logic signed [9:0] exp_n, exp_r;
   logic              rnd;
   logic [24:0]       man_r;
   logic [22:0]       frac;
   logic [31:0]       res_c;

   always_comb begin
      lead = 5'd0;
      for (int i = 0; i < 27; i++)
         if (s2_sum[i]) lead = i[4:0];
      shl = 5'd26 - lead;
      if (s2_sum[27]) begin
         norm  = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
         exp_n = $signed({2'b00, s2_exp}) + 10'sd1;
      end else begin
         norm  = s2_sum[26:0] << shl;
         exp_n = $signed({2'b00, s2_exp}) - $signed({5'd0, shl});
      end
      rnd   = norm[2] && (norm[1] || norm[0] || norm[3]);
      man_r = {1'b0, norm[26:3]} + {24'd0, rnd};
      exp_r = man_r[24] ? exp_n + 10'sd1 : exp_n;
      frac  = man_r[24] ? man_r[23:1] : man_r[22:0];
      if (s2_special)
         res_c = s2_spec_val;
      else if (s2_sum == 28'd0)
         res_c = {s2_sign & ~s2_sub, 31'd0};
      else if (exp_r >= 10'sd255)
         res_c = {s2_sign, 8'hff, 23'd0};
      else if (exp_r <= 10'sd0)
         res_c = {s2_sign, 31'd0};
      else
         res_c = {s2_sign, exp_r[7:0], frac};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         result    <= 32'd0;
         valid_out <= 1'b0;
      end else begin
         result    <= res_c;
         valid_out <= s2_valid;
      end
   end

endmodule

module residual_skip_join #(
   parameter int DATA_WIDTH   = 32,
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int CHANNEL_NUM  = 256,
   parameter int SKIP_DEPTH   = 4096,
   parameter int RELU_MODE    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_skip_in,
   input  logic [DATA_WIDTH-1:0]         skip_in,
   input  logic                          valid_main_in,
   input  logic [DATA_WIDTH-1:0]         main_in,
   output logic [DATA_WIDTH-1:0]         pxl_out,
   output logic                          valid_out,
   output logic [$clog2(SKIP_DEPTH):0]   fifo_level,
   output logic                          err_overflow,
   output logic                          err_underflow,
   output logic                          frame_done
);

   localparam int PTR_W = $clog2(SKIP_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int FRAME = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
   localparam int CNT_W = $clog2(FRAME + 1);

   function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
      logic is_nan;
      is_nan = (&x[30:23]) && (|x[22:0]);
      return (x[DATA_WIDTH-1] && !is_nan) ? '0 : x;
   endfunction

   logic [DATA_WIDTH-1:0] mem [SKIP_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic                  full, empty, pop, push, bypass, underflow, overflow;

   always_comb begin
      full      = (fifo_level == LVL_W'(SKIP_DEPTH));
      empty     = (fifo_level == '0);
      pop       = valid_main_in && !empty;
      bypass    = valid_main_in && empty && valid_skip_in;
      underflow = valid_main_in && empty && !valid_skip_in;
      // a bypassed skip word is consumed directly and never stored
      push      = valid_skip_in && !bypass && (!full || pop);
      overflow  = valid_skip_in && !bypass && full && !pop;
   end

   // Synchronous read; on a full push+pop both hit one address and the old head is read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= skip_in;
      if (pop)  rd_data     <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_level    <= fifo_level + LVL_W'(push) - LVL_W'(pop);
         err_overflow  <= err_overflow | overflow;
         err_underflow <= err_underflow | underflow;
      end
   end

   // Stage A: main operand plus the source of the skip operand
   logic                  a_valid, a_from_ram;
   logic [DATA_WIDTH-1:0] a_main, a_alt, skip_operand;

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_valid    <= 1'b0;
         a_from_ram <= 1'b0;
         a_main     <= '0;
         a_alt      <= '0;
      end else begin
         a_valid    <= valid_main_in;
         a_from_ram <= pop;
         a_main     <= (RELU_MODE == 2) ? relu(main_in) : main_in;
         a_alt      <= bypass ? skip_in : '0;
      end
   end

   assign skip_operand = a_from_ram ? rd_data : a_alt;

   logic [DATA_WIDTH-1:0] sum;
   logic                  sum_valid;

   fp_add_sub u_add (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (a_valid),
      .sub       (1'b0),
      .a         (a_main),
      .b         (skip_operand),
      .result    (sum),
      .valid_out (sum_valid)
   );

   // Stage C: optional ReLU after the add, output and frame counting
   logic [CNT_W-1:0] out_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pxl_out    <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         out_cnt    <= '0;
      end else begin
         valid_out  <= sum_valid;
         frame_done <= sum_valid && (out_cnt == CNT_W'(FRAME - 1));
         if (sum_valid) begin
            pxl_out <= (RELU_MODE == 1) ? relu(sum) : sum;
            out_cnt <= (out_cnt == CNT_W'(FRAME - 1)) ? '0 : out_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_residual_skip_join.sv
// Bench for residual_skip_join: three instances (ReLU modes 0/1/2) share stimulus and
// are compared against a queue/real-arithmetic reference model.

module tb_residual_skip_join;

   localparam int DEPTH = 8;
   localparam int LW    = 4;
   localparam int FRAME = 8;
   localparam int LAT   = 5;

   logic        clk = 1'b0;
   logic        reset, valid_skip_in, valid_main_in;
   logic [31:0] skip_in, main_in;
   logic [31:0] pxl [3];
   logic        vout [3];
   logic [LW-1:0] lvl [3];
   logic        ov [3], un [3], fd [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      residual_skip_join #(
         .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2),
         .SKIP_DEPTH(DEPTH), .RELU_MODE(g)
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .valid_skip_in (valid_skip_in),
         .skip_in       (skip_in),
         .valid_main_in (valid_main_in),
         .main_in       (main_in),
         .pxl_out       (pxl[g]),
         .valid_out     (vout[g]),
         .fifo_level    (lvl[g]),
         .err_overflow  (ov[g]),
         .err_underflow (un[g]),
         .frame_done    (fd[g])
      );
   end

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [95:0] exp_q [$];
   int          due_q [$];
   int          fd_idx [$];
   int          mcount = 0;
   logic        mon_on = 1'b0;
   logic [31:0] last_out [3];
   logic [31:0] mq [$];
   logic        m_ov = 1'b0, m_un = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      logic [24:0] man;
      logic        rnd;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e   = int'(d[62:52]) - 1023 + 127;
      man = {2'b01, d[51:29]};
      rnd = d[28] && ((|d[27:0]) || man[0]);
      man = man + 25'(rnd);
      if (man[24]) begin e = e + 1; man = man >> 1; end
      if (e >= 255) return {d[63], 8'hff, 23'd0};
      if (e <= 0) return {d[63], 31'd0};
      return {d[63], e[7:0], man[22:0]};
   endfunction

   function automatic logic [31:0] relu_m(input logic [31:0] x);
      if (x[31] && !(x[30:23] == 8'hff && x[22:0] != 23'd0)) return 32'd0;
      return x;
   endfunction

   function automatic logic [31:0] rnd_val();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // Scoreboard: outputs due LAT cycles after each accepted main word
   always @(negedge clk) begin
      if (mon_on) begin
         logic        exp_now;
         logic [95:0] e;
         e = '0;
         while (due_q.size() > 0 && due_q[0] < cyc) begin
            total++; bad++;
            $display("FAIL missing_output got=none exp_at_cycle=%0d now=%0d", due_q[0], cyc);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
         end
         exp_now = (due_q.size() > 0) && (due_q[0] == cyc);
         if (exp_now) begin
            mcount++;
            e = exp_q.pop_front();
            void'(due_q.pop_front());
         end
         for (int g = 0; g < 3; g++) begin
            total++;
            if (vout[g] !== exp_now) begin
               bad++;
               $display("FAIL valid_out dut%0d cycle=%0d got=%b exp=%b", g, cyc, vout[g], exp_now);
            end
            if (exp_now) begin
               total++;
               if (pxl[g] !== e[g*32 +: 32]) begin
                  bad++;
                  $display("FAIL pxl_out dut%0d cycle=%0d got=%h exp=%h", g, cyc, pxl[g], e[g*32 +: 32]);
               end
               last_out[g] = pxl[g];
            end
            total++;
            if (fd[g] !== (exp_now && (mcount % FRAME == 0))) begin
               bad++;
               $display("FAIL frame_done dut%0d cycle=%0d got=%b exp=%b", g, cyc, fd[g],
                        exp_now && (mcount % FRAME == 0));
            end
         end
         if (exp_now && fd[1] === 1'b1) fd_idx.push_back(mcount);
         if (reset === 1'b0) begin
            exp_q.delete();
            due_q.delete();
            mcount = 0;
         end
      end
   end

   // Apply one cycle of inputs, advance the reference model, return 1 after the edge
   task automatic drive(input logic vs, input logic [31:0] s, input logic vm, input logic [31:0] m);
      logic [31:0] op, r0, r1, r2;
      logic        bypassed;
      op = 32'd0;
      bypassed = 1'b0;
      valid_skip_in = vs; skip_in = s; valid_main_in = vm; main_in = m;
      if (vm) begin
         if (mq.size() > 0) op = mq.pop_front();
         else if (vs) begin op = s; bypassed = 1'b1; end
         else m_un = 1'b1;
      end
      if (vs && !bypassed) begin
         if (mq.size() < DEPTH) mq.push_back(s);
         else m_ov = 1'b1;
      end
      if (vm) begin
         r0 = r2f(f2r(m) + f2r(op));
         r1 = relu_m(r0);
         r2 = r2f(f2r(relu_m(m)) + f2r(op));
         exp_q.push_back({r2, r1, r0});
         due_q.push_back(cyc + LAT);
      end
      @(posedge clk);
      #1;
      valid_skip_in = 1'b0; valid_main_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      valid_skip_in = 1'b0; valid_main_in = 1'b0;
      mq.delete(); m_ov = 1'b0; m_un = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      valid_skip_in = 1'b0; valid_main_in = 1'b0; skip_in = 32'd0; main_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         total++;
         if ({pxl[g], vout[g], lvl[g], ov[g], un[g], fd[g]} !== '0) begin
            bad++;
            $display("FAIL reset_state dut%0d got pxl=%h v=%b lvl=%0d ov=%b un=%b fd=%b exp=all_zero",
                     g, pxl[g], vout[g], lvl[g], ov[g], un[g], fd[g]);
         end
      end
      reset = 1'b1;
      mon_on = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] skips [4];
      skips = '{32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, skips[i], 1'b0, 32'd0);
         total++;
         if (lvl[1] !== LW'(i + 1)) begin
            bad++; $display("FAIL basic_fill_level got=%0d exp=%0d", lvl[1], i + 1);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'd0, 1'b1, 32'h3f00_0000);
         total++;
         if (lvl[1] !== LW'(3 - i)) begin
            bad++; $display("FAIL basic_drain_level got=%0d exp=%0d", lvl[1], 3 - i);
         end
      end
      idle(7);
      total++;
      if (last_out[1] !== 32'h4090_0000) begin
         bad++; $display("FAIL basic_last_sum got=%h exp=40900000", last_out[1]);
      end
      total++;
      if ({ov[1], un[1]} !== 2'b00) begin
         bad++; $display("FAIL basic_errors got=%b%b exp=00", ov[1], un[1]);
      end
   endtask

   task automatic test_relu_modes();
      drive(1'b1, 32'h3f80_0000, 1'b0, 32'd0);
      drive(1'b0, 32'd0, 1'b1, 32'hc040_0000);
      idle(7);
      total++;
      if (last_out[0] !== 32'hc000_0000) begin
         bad++; $display("FAIL relu_mode0 got=%h exp=c0000000", last_out[0]);
      end
      total++;
      if (last_out[1] !== 32'h0000_0000) begin
         bad++; $display("FAIL relu_mode1 got=%h exp=00000000", last_out[1]);
      end
      total++;
      if (last_out[2] !== 32'h3f80_0000) begin
         bad++; $display("FAIL relu_mode2 got=%h exp=3f800000", last_out[2]);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, rnd_val(), 1'b0, 32'd0);
      drive(1'b1, rnd_val(), 1'b1, rnd_val());
      total++;
      if (lvl[1] !== LW'(DEPTH) || ov[1] !== 1'b0) begin
         bad++; $display("FAIL full_push_pop got lvl=%0d ov=%b exp lvl=%0d ov=0", lvl[1], ov[1], DEPTH);
      end
      drive(1'b1, rnd_val(), 1'b0, 32'd0);
      total++;
      if (lvl[1] !== LW'(DEPTH) || ov[1] !== 1'b1) begin
         bad++; $display("FAIL overflow got lvl=%0d ov=%b exp lvl=%0d ov=1", lvl[1], ov[1], DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'd0, 1'b1, rnd_val());
      idle(7);
      total++;
      if (lvl[1] !== '0 || due_q.size() != 0) begin
         bad++; $display("FAIL overflow_drain got lvl=%0d pending=%0d exp 0 0", lvl[1], due_q.size());
      end
   endtask

   task automatic test_underflow();
      apply_reset();
      drive(1'b0, 32'd0, 1'b1, 32'h40a0_0000);
      total++;
      if (un[1] !== 1'b1 || lvl[1] !== '0) begin
         bad++; $display("FAIL underflow_flag got un=%b lvl=%0d exp un=1 lvl=0", un[1], lvl[1]);
      end
      idle(7);
      total++;
      if (last_out[1] !== 32'h40a0_0000) begin
         bad++; $display("FAIL underflow_sum got=%h exp=40a00000", last_out[1]);
      end
      apply_reset();
      drive(1'b1, 32'h4000_0000, 1'b1, 32'h3f80_0000);
      total++;
      if (un[1] !== 1'b0 || ov[1] !== 1'b0 || lvl[1] !== '0) begin
         bad++; $display("FAIL bypass_flags got un=%b ov=%b lvl=%0d exp 0 0 0", un[1], ov[1], lvl[1]);
      end
      idle(7);
      total++;
      if (last_out[1] !== 32'h4040_0000) begin
         bad++; $display("FAIL bypass_sum got=%h exp=40400000", last_out[1]);
      end
   endtask

   task automatic test_frame();
      apply_reset();
      fd_idx.delete();
      for (int i = 0; i < 2; i++) drive(1'b1, rnd_val(), 1'b0, 32'd0);
      for (int i = 0; i < 14; i++) drive(1'b1, rnd_val(), 1'b1, rnd_val());
      for (int i = 0; i < 2; i++) drive(1'b0, 32'd0, 1'b1, rnd_val());
      idle(7);
      total++;
      if (fd_idx.size() != 2 || fd_idx[0] != 8 || fd_idx[1] != 16) begin
         bad++;
         $display("FAIL frame_pulses got count=%0d first=%0d exp count=2 at 8,16",
                  fd_idx.size(), (fd_idx.size() > 0) ? fd_idx[0] : -1);
      end
   endtask

   task automatic test_random();
      logic vs, vm;
      apply_reset();
      for (int i = 0; i < 200; i++) begin
         vs = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH || $urandom_range(0, 7) == 0);
         vm = ($urandom_range(0, 2) != 0) && (mq.size() > 0 || $urandom_range(0, 15) == 0);
         drive(vs, rnd_val(), vm, rnd_val());
         for (int g = 0; g < 3; g++) begin
            total++;
            if (lvl[g] !== LW'(mq.size()) || ov[g] !== m_ov || un[g] !== m_un) begin
               bad++;
               $display("FAIL random_state dut%0d step=%0d got lvl=%0d ov=%b un=%b exp lvl=%0d ov=%b un=%b",
                        g, i, lvl[g], ov[g], un[g], mq.size(), m_ov, m_un);
            end
         end
      end
      while (mq.size() > 0) drive(1'b0, 32'd0, 1'b1, rnd_val());
      idle(7);
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      for (int i = 0; i < 8; i++) drive(1'b1, rnd_val(), 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, rnd_val());
      apply_reset();
      for (int g = 0; g < 3; g++) begin
         total++;
         if ({pxl[g], vout[g], lvl[g], ov[g], un[g], fd[g]} !== '0) begin
            bad++;
            $display("FAIL midflight_reset dut%0d got pxl=%h v=%b lvl=%0d exp=all_zero",
                     g, pxl[g], vout[g], lvl[g]);
         end
      end
      drive(1'b1, rnd_val(), 1'b0, 32'd0);
      drive(1'b1, rnd_val(), 1'b0, 32'd0);
      total++;
      if (lvl[1] !== LW'(2)) begin
         bad++; $display("FAIL midflight_level got=%0d exp=2", lvl[1]);
      end
      drive(1'b0, 32'd0, 1'b1, rnd_val());
      drive(1'b0, 32'd0, 1'b1, rnd_val());
      idle(7);
      total++;
      if (due_q.size() != 0 || lvl[1] !== '0) begin
         bad++; $display("FAIL midflight_drain got pending=%0d lvl=%0d exp 0 0", due_q.size(), lvl[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu_modes();
      test_overflow();
      test_underflow();
      test_frame();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/residual_skip_join.md
# residual_skip_join

Parametrised residual join for bottleneck/identity blocks. The block buffers the shortcut (skip) stream in an on-chip FIFO sized by parameter, not by cascaded line buffers. It pops one skip word per main-path word and adds the pair with the team's fp_add_sub. It also applies a selectable ReLU placement, reports FIFO occupancy, under/overflow and end-of-frame, and sits between the last conv of a residual branch and the next block's input.

## Interface
- DATA_WIDTH, 32: IEEE-754 word width
- IMAGE_WIDTH, 128: pixels per row
- IMAGE_HEIGHT, 128: rows per frame
- CHANNEL_NUM, 256: channels per pixel; frame = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM words
- SKIP_DEPTH, 4096: FIFO entries, power of two, ≥2
- RELU_MODE, 1: 0 none, 1 ReLU after add, 2 ReLU on main operand before add
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- valid_skip_in  in  1  skip word valid
- skip_in  in  DATA_WIDTH  skip word
- valid_main_in  in  1  main-path word valid
- main_in  in  DATA_WIDTH  main-path word
- pxl_out  out  DATA_WIDTH  sum (post-ReLU per mode)
- valid_out  out  1  pxl_out valid
- fifo_level  out  $clog2(SKIP_DEPTH)+1  stored skip words
- err_overflow  out  1  sticky: skip word dropped
- err_underflow  out  1  sticky: main word with no skip word
- frame_done  out  1  one-cycle pulse with last word of frame

## Operation
- Push: valid_skip_in writes skip_in at wr_ptr if not full, or if a pop occurs the same cycle. Full with no pop: word dropped, err_overflow set.
- Pop: valid_main_in reads head. If empty and push same cycle: bypass, so the incoming skip_in is the operand, level unchanged, no error. If empty, no push: operand = +0.0, err_underflow set, output still produced.
- Pointers wrap modulo SKIP_DEPTH. fifo_level = pushes − pops accepted. Simultaneous push+pop leaves level unchanged.
- Stage A (registered, 1 cycle): main operand, or ReLU(main) if RELU_MODE=2, plus skip operand from RAM/bypass/zero.
- Stage B: fp_add_sub, latency L_ADD, valid chained through the adder's own valid.
- Stage C (registered, 1 cycle): ReLU(sum) if RELU_MODE=1, else pass-through. ReLU means sign bit set gives +0.0, −0.0 gives +0.0, NaN passes unchanged.
- Output counter counts valid_out. frame_done asserts with the frame's last word, then the counter returns to 0.
- Errors are sticky until reset. Reset mid-frame discards FIFO contents, in-flight pipeline, and counters.

## Timing
- Reset values: pxl_out 0, valid_out 0, fifo_level 0, err_* 0, frame_done 0, pointers/counter 0.
- Latency valid_main_in → valid_out = L_ADD + 2 cycles, identical in all modes and in bypass/underflow.
- Throughput: one word per cycle on each input, no backpressure. Upstream guarantees skip leads main by ≤ SKIP_DEPTH words.
- The RAM read is synchronous. The head word is valid one cycle after pop and is consumed in Stage A.
- fifo_level and err_* update the cycle after the causing edge.

## Test plan
- Reset, push 4 skip words 1.0,2.0,3.0,4.0, then 4 main words 0.5 each, RELU_MODE=1 → outputs 1.5,2.5,3.5,4.5 at L_ADD+2 after each main valid; fifo_level 4→0; no errors.
- RELU_MODE=1, skip 1.0, main −3.0 → pxl_out +0.0. RELU_MODE=2, same inputs → pxl_out 1.0. RELU_MODE=0 → pxl_out −2.0.
- Fill SKIP_DEPTH words, push one more without pop → dropped word, err_overflow=1, level stays SKIP_DEPTH. Repeat with simultaneous pop → accepted, no error.
- Empty FIFO, main 5.0 without push → out 5.0, err_underflow=1. Empty with push 2.0 and main 1.0 same cycle → out 3.0, no error, level 0.
- IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM=2, stream 16 word pairs → frame_done pulses exactly on outputs 8 and 16.
- Assert reset at word 3 of 8 in flight, then resume → all outputs/flags zero next cycle; the new stream of 2 pairs yields correct sums with level starting at 0.
